dl_bitscan_iter: RTL and testbench

DL_BITSCAN_ITER -- requirements
Module: dl_bitscan_iter

---
 rtl/dl_bitscan_iter_if.sv | 38 +++
 rtl/dl_bitscan_iter.sv | 87 ++++++++
 tb/tb_dl_bitscan_iter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dl_bitscan_iter_if.sv
// Handshake bundle for dl_bitscan_iter: mask input stream plus index output stream.
// The DUT connects via the slave modport; the environment drives the master modport.
interface dl_bitscan_iter_if #(
  parameter int unsigned NUM_BITS = 8
);
  localparam int unsigned IDX_W = $clog2(NUM_BITS);

  logic                in_vld;
  logic                in_rdy;
  logic [NUM_BITS-1:0] in_mask;
  logic                out_vld;
  logic                out_rdy;
  logic [IDX_W-1:0]    out_idx;
  logic                out_last;
  logic                zero_drop;

  modport master (
    output in_vld,
    output in_mask,
    output out_rdy,
    input  in_rdy,
    input  out_vld,
    input  out_idx,
    input  out_last,
    input  zero_drop
  );

  modport slave (
    input  in_vld,
    input  in_mask,
    input  out_rdy,
    output in_rdy,
    output out_vld,
    output out_idx,
    output out_last,
    output zero_drop
  );
endinterface

// File: rtl/dl_bitscan_iter.sv
// Decomposes an accepted bit mask into the indices of its set bits, LSB first,
// one index per output handshake.
module dl_bitscan_iter #(
  parameter int unsigned NUM_BITS = 8
) (
  input logic             clk,
  input logic             rst,
  dl_bitscan_iter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_BITS);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] res_q, res_d;
  logic                zero_q, zero_d;

  logic [IDX_W-1:0]    low_idx;
  logic [NUM_BITS-1:0] res_cleared;
  logic                res_single;

  // Priority encoder: scanning downward leaves the lowest set bit's index.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_BITS - 1; i >= 0; i--) begin
      if (res_q[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  // x & (x-1) drops the lowest set bit; a zero result means at most one bit was set.
  assign res_cleared = res_q & (res_q - NUM_BITS'(1));
  assign res_single  = (res_q != '0) && (res_cleared == '0);

  always_comb begin
    state_d       = state_q;
    res_d         = res_q;
    zero_d        = 1'b0;
    bus.in_rdy    = 1'b0;
    bus.out_vld   = 1'b0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    bus.zero_drop = zero_q;

    unique case (state_q)
      StIdle: begin
        bus.in_rdy = 1'b1;
        if (bus.in_vld) begin
          if (bus.in_mask != '0) begin
            res_d   = bus.in_mask;
            state_d = StScan;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      StScan: begin
        bus.out_vld  = 1'b1;
        bus.out_idx  = low_idx;
        bus.out_last = res_single;
        if (bus.out_rdy) begin
          res_d = res_cleared;
          if (res_single) begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        res_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: tb/tb_dl_bitscan_iter.sv
// Directed table-driven bench for dl_bitscan_iter with NUM_BITS=8, plus a
// hand-written mid-scan reset sequence.
module tb_dl_bitscan_iter;
  localparam int unsigned NB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dl_bitscan_iter_if #(.NUM_BITS(NB)) bus ();

  dl_bitscan_iter #(.NUM_BITS(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic       vld;
    logic [7:0] mask;
    logic       ordy;
    logic       e_rdy;
    logic       e_ovld;
    logic [2:0] e_idx;
    logic       e_last;
    logic       e_zd;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t v[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic ovld,
                         input logic [2:0] idx, input logic last, input logic zd);
    chk({tag, ".in_rdy"},    {7'd0, bus.in_rdy},    {7'd0, rdy});
    chk({tag, ".out_vld"},   {7'd0, bus.out_vld},   {7'd0, ovld});
    chk({tag, ".out_idx"},   {5'd0, bus.out_idx},   {5'd0, idx});
    chk({tag, ".out_last"},  {7'd0, bus.out_last},  {7'd0, last});
    chk({tag, ".zero_drop"}, {7'd0, bus.zero_drop}, {7'd0, zd});
  endtask

  // Inputs applied this cycle; expected outputs reflect state before the next edge.
  function automatic vec_t mk(logic vld, logic [7:0] mask, logic ordy, logic rdy,
                              logic ovld, logic [2:0] idx, logic last, logic zd);
    vec_t r;
    r.vld = vld; r.mask = mask; r.ordy = ordy;
    r.e_rdy = rdy; r.e_ovld = ovld; r.e_idx = idx; r.e_last = last; r.e_zd = zd;
    return r;
  endfunction

  initial begin
    bus.in_vld  = 1'b0;
    bus.in_mask = '0;
    bus.out_rdy = 1'b1;

    // A4: indices 2,5,7 then idle
    v.push_back(mk(1, 8'hA4, 1, 1, 0, 0, 0, 0));
    v.push_back(mk(0, 8'h00, 1, 0, 1, 2, 0, 0));
    v.push_back(mk(0, 8'h00, 1, 0, 1, 5, 0, 0));
    v.push_back(mk(0, 8'h00, 1, 0, 1, 7, 1, 0));
    // Zero mask: accepted from idle, pulse next cycle only
    v.push_back(mk(1, 8'h00, 1, 1, 0, 0, 0, 0));
    v.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 1));
    // 81 with three stalled cycles
    v.push_back(mk(1, 8'h81, 0, 1, 0, 0, 0, 0));
    v.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0));
    v.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0));
    v.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0));
    v.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 0));
    v.push_back(mk(0, 8'h00, 1, 0, 1, 7, 1, 0));
    // FF: 0..7 over 8 cycles
    v.push_back(mk(1, 8'hFF, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      v.push_back(mk(0, 8'h00, 1, 0, 1, 3'(i), (i == 7), 0));
    end
    // Back-to-back with in_vld held and mask changing mid-scan
    v.push_back(mk(1, 8'h01, 1, 1, 0, 0, 0, 0));
    v.push_back(mk(1, 8'h40, 1, 0, 1, 0, 1, 0));
    v.push_back(mk(1, 8'h02, 1, 1, 0, 0, 0, 0));
    v.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 0));
    v.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0));

    #12;
    chk_all("reset", 1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (v[k]) begin
      bus.in_vld  = v[k].vld;
      bus.in_mask = v[k].mask;
      bus.out_rdy = v[k].ordy;
      chk_all($sformatf("vec%0d", k), v[k].e_rdy, v[k].e_ovld, v[k].e_idx,
              v[k].e_last, v[k].e_zd);
      @(negedge clk);
    end

    // Mid-scan reset after the index-4 handshake
    bus.in_vld  = 1'b1;
    bus.in_mask = 8'hF0;
    bus.out_rdy = 1'b1;
    @(negedge clk);
    bus.in_vld = 1'b0;
    chk_all("f0_idx4", 0, 1, 4, 0, 0);
    @(negedge clk);
    chk_all("f0_idx5", 0, 1, 5, 0, 0);
    rst = 1'b1;
    #1;
    chk_all("midrst", 1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    chk_all("postrst0", 1, 0, 0, 0, 0);
    @(negedge clk);
    chk_all("postrst1", 1, 0, 0, 0, 0);
    bus.in_vld  = 1'b1;
    bus.in_mask = 8'h02;
    @(negedge clk);
    bus.in_vld = 1'b0;
    chk_all("m02_idx1", 0, 1, 1, 1, 0);
    @(negedge clk);
    chk_all("m02_idle", 1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
